// File: rtl/line_window_3x3.sv
// line_window_3x3: raster-to-window stage feeding the 3x3 kernel blocks.
// Accepts one 8-bit pixel per beat in row-major order, keeps the two previous
// rows in line memories and emits the nine pixels of every interior 3x3
// neighbourhood, one cycle after the pixel that completes it is accepted.
// Optional feature macro: READY_EN adds the m_ready port and full backpressure.
module line_window_3x3 #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       s_valid,
    input  logic [7:0] s_data,
    input  logic       s_sof,
    output logic       s_ready,
    output logic       m_valid,
`ifdef READY_EN
    input  logic       m_ready,
`endif
    output logic [7:0] p1,
    output logic [7:0] p2,
    output logic [7:0] p3,
    output logic [7:0] p4,
    output logic [7:0] p5,
    output logic [7:0] p6,
    output logic [7:0] p7,
    output logic [7:0] p8,
    output logic [7:0] p9,
    output logic       m_eol,
    output logic       m_eof
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(IMG_H - 1);

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [CW-1:0] curCol;
    logic [RW-1:0] curRow;
    logic          accept;
    logic          emit;
    logic          lastCol;
    logic          lastRow;

    // lb1 holds row r-1, lb0 holds row r-2; both addressed by column.
    logic [7:0] lb0 [IMG_W];
    logic [7:0] lb1 [IMG_W];
    logic [7:0] lb0Rd;
    logic [7:0] lb1Rd;

    // Two stored window columns (A = older, B = newer); the third, newest
    // column is taken straight from the line-memory reads and s_data.
    logic [7:0] topA, topB, midA, midB, botA, botB;

`ifdef READY_EN
    assign s_ready = !m_valid || m_ready;
`else
    assign s_ready = 1'b1;
`endif

    // A start-of-frame pixel is placed at (0,0) whatever the counters say.
    assign accept  = s_valid && s_ready;
    assign curCol  = s_sof ? '0 : col;
    assign curRow  = s_sof ? '0 : row;
    assign lastCol = (curCol == LAST_COL);
    assign lastRow = (curRow == LAST_ROW);
    assign emit    = accept && (curRow >= RW'(2)) && (curCol >= CW'(2));

    // Asynchronous reads give the old contents when the same address is
    // written on this edge, which is exactly the row hand-off we need.
    assign lb0Rd = lb0[curCol];
    assign lb1Rd = lb1[curCol];

    // Position counters advance on every accepted pixel, wrapping per row and frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (lastCol) begin
                col <= '0;
                row <= lastRow ? '0 : curRow + RW'(1);
            end else begin
                col <= curCol + CW'(1);
                row <= curRow;
            end
        end
    end

    // Line memories: row r-1 moves down to r-2, the incoming pixel becomes row r-1.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb0[curCol] <= lb1Rd;
            lb1[curCol] <= s_data;
        end
    end

    // Window columns shift left on each accept, new column enters on the right.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            topA <= '0; topB <= '0;
            midA <= '0; midB <= '0;
            botA <= '0; botB <= '0;
        end else if (accept) begin
            topA <= topB; topB <= lb0Rd;
            midA <= midB; midB <= lb1Rd;
            botA <= botB; botB <= s_data;
        end
    end

    // Output registers load on the accept that completes an interior window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_eol   <= 1'b0;
            m_eof   <= 1'b0;
            p1 <= '0; p2 <= '0; p3 <= '0;
            p4 <= '0; p5 <= '0; p6 <= '0;
            p7 <= '0; p8 <= '0; p9 <= '0;
        end else if (emit) begin
            m_valid <= 1'b1;
            m_eol   <= lastCol;
            m_eof   <= lastCol && lastRow;
            p1 <= topA; p2 <= topB; p3 <= lb0Rd;
            p4 <= midA; p5 <= midB; p6 <= lb1Rd;
            p7 <= botA; p8 <= botB; p9 <= s_data;
`ifdef READY_EN
        end else if (m_ready) begin
            m_valid <= 1'b0;
`else
        end else begin
            m_valid <= 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_line_window_3x3.sv
// tb_line_window_3x3: directed bench for line_window_3x3 on an 8x6 image
// whose pixel value is r*16+c. Build with READY_EN defined to also exercise
// the backpressure path.
module tb_line_window_3x3;

    localparam int W = 8;
    localparam int H = 6;
    localparam int NWIN = (W - 2) * (H - 2);

    typedef struct packed {
        logic [71:0] pix;
        logic        eol;
        logic        eof;
    } winT;

    logic       clk = 1'b0;
    logic       rst;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_sof;
    logic       s_ready;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] p1, p2, p3, p4, p5, p6, p7, p8, p9;
    logic       m_eol;
    logic       m_eof;

    winT winQ[$];
    winT cap;
    int  vectors = 0;
    int  miscompares = 0;

    line_window_3x3 #(.IMG_W(W), .IMG_H(H)) dut (
        .clk(clk),
        .rst(rst),
        .s_valid(s_valid),
        .s_data(s_data),
        .s_sof(s_sof),
        .s_ready(s_ready),
        .m_valid(m_valid),
`ifdef READY_EN
        .m_ready(m_ready),
`endif
        .p1(p1), .p2(p2), .p3(p3),
        .p4(p4), .p5(p5), .p6(p6),
        .p7(p7), .p8(p8), .p9(p9),
        .m_eol(m_eol),
        .m_eof(m_eof)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Collect every window handed over downstream, sampled mid-cycle.
    always @(negedge clk) begin
        if (m_valid === 1'b1 && m_ready === 1'b1) begin
            cap.pix = {p1, p2, p3, p4, p5, p6, p7, p8, p9};
            cap.eol = m_eol;
            cap.eof = m_eof;
            winQ.push_back(cap);
        end
    end

    // Expected k-th window of a clean frame, built from the r*16+c pattern.
    function automatic winT expWin(input int k);
        winT w;
        int  r;
        int  c;
        r = 2 + k / (W - 2);
        c = 2 + k % (W - 2);
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w.pix[71 - 8 * (i * 3 + j) -: 8] = 8'((r - 2 + i) * 16 + (c - 2 + j));
        w.eol = (c == W - 1);
        w.eof = (c == W - 1) && (r == H - 1);
        return w;
    endfunction

    task automatic idle(input int n);
        s_valid = 1'b0;
        s_sof   = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one pixel and hold it until accepted (bounded wait).
    task automatic sendPixel(input logic [7:0] d, input logic sof);
        bit acc;
        acc = 1'b0;
        s_valid = 1'b1;
        s_data  = d;
        s_sof   = sof;
        for (int t = 0; t < 100 && !acc; t++) begin
            @(negedge clk);
            acc = s_ready;
            @(posedge clk);
            #1;
        end
        vectors++;
        if (!acc) begin
            miscompares++;
            $display("[TB] FAIL accept_timeout pixel=%h got s_ready=0 want accept within 100 cycles", d);
        end
        s_valid = 1'b0;
        s_sof   = 1'b0;
    endtask

    // Stream the first n pixels of a frame; optionally with gaps and a
    // per-pixel check that m_valid rises exactly one cycle after interior pixels.
    task automatic sendRows(input bit sofFirst, input int n, input bit gaps, input bit chkLat);
        for (int i = 0; i < n; i++) begin
            int r;
            int c;
            r = i / W;
            c = i % W;
            if (gaps && $urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
            sendPixel(8'(r * 16 + c), sofFirst && (i == 0));
            if (chkLat) begin
                vectors++;
                if (m_valid !== ((r >= 2) && (c >= 2))) begin
                    miscompares++;
                    $display("[TB] FAIL latency r=%0d c=%0d got m_valid=%b want %b", r, c, m_valid, (r >= 2) && (c >= 2));
                end
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        vectors++;
        if ({m_valid, m_eol, m_eof, p1, p2, p3, p4, p5, p6, p7, p8, p9} !== 75'd0 || s_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset_state got m_valid=%b eol=%b eof=%b p=%h s_ready=%b want zeros, s_ready=1",
                     m_valid, m_eol, m_eof, {p1, p2, p3, p4, p5, p6, p7, p8, p9}, s_ready);
        end
        rst = 1'b0;
        idle(2);
        vectors++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL post_reset_idle got m_valid=%b s_ready=%b want 0/1", m_valid, s_ready);
        end
    endtask

    task automatic test_single_frame;
        int  base;
        winT got;
        winT exp;
        base = winQ.size();
        sendRows(1'b1, W * H, 1'b0, 1'b1);
        idle(3);
        vectors++;
        if (winQ.size() - base != NWIN) begin
            miscompares++;
            $display("[TB] FAIL single_frame_count got %0d want %0d", winQ.size() - base, NWIN);
        end
        for (int k = 0; k < NWIN; k++) begin
            if (base + k < winQ.size()) begin
                got = winQ[base + k];
                exp = expWin(k);
                vectors++;
                if (got !== exp) begin
                    miscompares++;
                    $display("[TB] FAIL single_frame win%0d got pix=%h eol=%b eof=%b want pix=%h eol=%b eof=%b",
                             k, got.pix, got.eol, got.eof, exp.pix, exp.eol, exp.eof);
                end
            end
        end
    endtask

    task automatic test_back_to_back;
        int  base;
        winT got;
        winT exp;
        base = winQ.size();
        sendRows(1'b1, W * H, 1'b0, 1'b1);
        sendRows(1'b1, W * H, 1'b0, 1'b1);
        idle(3);
        vectors++;
        if (winQ.size() - base != 2 * NWIN) begin
            miscompares++;
            $display("[TB] FAIL back_to_back_count got %0d want %0d", winQ.size() - base, 2 * NWIN);
        end
        for (int k = 0; k < 2 * NWIN; k++) begin
            if (base + k < winQ.size()) begin
                got = winQ[base + k];
                exp = expWin(k % NWIN);
                vectors++;
                if (got !== exp) begin
                    miscompares++;
                    $display("[TB] FAIL back_to_back win%0d got pix=%h eol=%b eof=%b want pix=%h eol=%b eof=%b",
                             k, got.pix, got.eol, got.eof, exp.pix, exp.eol, exp.eof);
                end
            end
        end
    endtask

    // Abandon a frame at (3,4) with a fresh start-of-frame.
    task automatic test_sof_restart;
        int  base;
        winT got;
        winT exp;
        base = winQ.size();
        sendRows(1'b1, 3 * W + 4, 1'b0, 1'b1);
        sendRows(1'b1, W * H, 1'b0, 1'b1);
        idle(3);
        vectors++;
        if (winQ.size() - base != 8 + NWIN) begin
            miscompares++;
            $display("[TB] FAIL sof_restart_count got %0d want %0d", winQ.size() - base, 8 + NWIN);
        end
        for (int k = 0; k < 8 + NWIN; k++) begin
            if (base + k < winQ.size()) begin
                got = winQ[base + k];
                exp = (k < 8) ? expWin(k) : expWin(k - 8);
                vectors++;
                if (got !== exp) begin
                    miscompares++;
                    $display("[TB] FAIL sof_restart win%0d got pix=%h eol=%b eof=%b want pix=%h eol=%b eof=%b",
                             k, got.pix, got.eol, got.eof, exp.pix, exp.eol, exp.eof);
                end
            end
        end
    endtask

    task automatic test_gaps;
        int  base;
        winT got;
        winT exp;
        base = winQ.size();
        sendRows(1'b1, W * H, 1'b1, 1'b1);
        idle(3);
        vectors++;
        if (winQ.size() - base != NWIN) begin
            miscompares++;
            $display("[TB] FAIL gaps_count got %0d want %0d", winQ.size() - base, NWIN);
        end
        for (int k = 0; k < NWIN; k++) begin
            if (base + k < winQ.size()) begin
                got = winQ[base + k];
                exp = expWin(k);
                vectors++;
                if (got !== exp) begin
                    miscompares++;
                    $display("[TB] FAIL gaps win%0d got pix=%h eol=%b eof=%b want pix=%h eol=%b eof=%b",
                             k, got.pix, got.eol, got.eof, exp.pix, exp.eol, exp.eof);
                end
            end
        end
    endtask

`ifdef READY_EN
    // Stall the first window for 5 cycles while the source keeps pushing.
    task automatic test_backpressure;
        int  base;
        winT got;
        winT exp;
        base = winQ.size();
        fork
            sendRows(1'b1, W * H, 1'b0, 1'b0);
            begin
                bit  seen;
                winT snap;
                winT now;
                seen = 1'b0;
                for (int t = 0; t < 500 && !seen; t++) begin
                    @(posedge clk);
                    #1;
                    seen = (m_valid === 1'b1);
                end
                vectors++;
                if (!seen) begin
                    miscompares++;
                    $display("[TB] FAIL stall_wait got no m_valid want m_valid within 500 cycles");
                end else begin
                    m_ready = 1'b0;
                    snap.pix = {p1, p2, p3, p4, p5, p6, p7, p8, p9};
                    snap.eol = m_eol;
                    snap.eof = m_eof;
                    repeat (5) begin
                        @(negedge clk);
                        now.pix = {p1, p2, p3, p4, p5, p6, p7, p8, p9};
                        now.eol = m_eol;
                        now.eof = m_eof;
                        vectors++;
                        if (s_ready !== 1'b0 || m_valid !== 1'b1 || now !== snap) begin
                            miscompares++;
                            $display("[TB] FAIL stall_hold got s_ready=%b m_valid=%b pix=%h want 0/1 pix=%h",
                                     s_ready, m_valid, now.pix, snap.pix);
                        end
                        @(posedge clk);
                        #1;
                    end
                    m_ready = 1'b1;
                end
            end
        join
        idle(3);
        vectors++;
        if (winQ.size() - base != NWIN) begin
            miscompares++;
            $display("[TB] FAIL backpressure_count got %0d want %0d", winQ.size() - base, NWIN);
        end
        for (int k = 0; k < NWIN; k++) begin
            if (base + k < winQ.size()) begin
                got = winQ[base + k];
                exp = expWin(k);
                vectors++;
                if (got !== exp) begin
                    miscompares++;
                    $display("[TB] FAIL backpressure win%0d got pix=%h eol=%b eof=%b want pix=%h eol=%b eof=%b",
                             k, got.pix, got.eol, got.eof, exp.pix, exp.eol, exp.eof);
                end
            end
        end
    endtask
`endif

    // Reset in the middle of row 3, then stream a frame with no s_sof at all.
    task automatic test_mid_reset;
        int  base;
        winT got;
        winT exp;
        sendRows(1'b1, 3 * W + 4, 1'b0, 1'b1);
        rst = 1'b1;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            vectors++;
            if ({m_valid, m_eol, m_eof, p1, p2, p3, p4, p5, p6, p7, p8, p9} !== 75'd0) begin
                miscompares++;
                $display("[TB] FAIL mid_reset_outputs got m_valid=%b p=%h want all zero",
                         m_valid, {p1, p2, p3, p4, p5, p6, p7, p8, p9});
            end
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        idle(1);
        base = winQ.size();
        sendRows(1'b0, W * H, 1'b0, 1'b1);
        idle(3);
        vectors++;
        if (winQ.size() - base != NWIN) begin
            miscompares++;
            $display("[TB] FAIL mid_reset_count got %0d want %0d", winQ.size() - base, NWIN);
        end
        for (int k = 0; k < NWIN; k++) begin
            if (base + k < winQ.size()) begin
                got = winQ[base + k];
                exp = expWin(k);
                vectors++;
                if (got !== exp) begin
                    miscompares++;
                    $display("[TB] FAIL mid_reset win%0d got pix=%h eol=%b eof=%b want pix=%h eol=%b eof=%b",
                             k, got.pix, got.eol, got.eof, exp.pix, exp.eol, exp.eof);
                end
            end
        end
    endtask

    // Run every scenario in order, then report.
    initial begin
        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = 8'h00;
        s_sof   = 1'b0;
        m_ready = 1'b1;
        test_reset;
        test_single_frame;
        test_back_to_back;
        test_sof_restart;
        test_gaps;
`ifdef READY_EN
        test_backpressure;
`endif
        test_mid_reset;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
